wb_port_arbiter: RTL

Shares the single register-file write port between three requesters:
- the in-order pipeline writeback (ALU/IMM/PC results, no backpressure)
- the load-return path (memory data already shifted and extended)
- the multi-cycle mul/div unit

Pipeline has fixed priority. Load and MDU share leftover slots round-robin. A starvation FSM forces a pipeline bubble when a secondary requester waits too long. The output stage is registered and drives the register file write port directly.

---
 rtl/wb_port_arbiter_pkg.sv | 28 ++
 rtl/wb_port_arbiter_rr_arb2.sv | 32 +++
 rtl/wb_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Pure declarations; no logic, no latency.
// No flow control here; consumers define their own handshakes.
package cpu_consts;

    localparam int WB_STARVE_LIMIT_DEFAULT = 4;

    // Which requester owns the write port in a given cycle
    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_LD,
        WB_MDU
    } wb_src_e;

    // Starvation watchdog states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BUBBLE
    } starve_state_e;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; pointer favours index 0 (load) after reset.
// Grant is combinational from req in the same cycle; pointer updates on advance.
// No backpressure of its own: a lone requester always wins, ties go to the pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       advance
);

    // ptr_q == 0 : index 0 wins a tie; ptr_q == 1 : index 1 wins a tie
    logic ptr_q;

    // Tie-break only when both request; otherwise pass the single request through
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After any grant, point at the source that did not just win
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline > {load, MDU round-robin}, with starvation bubble.
// Grant and ready are combinational in cycle N; the RF write appears registered in N+1.
// Pipeline is never backpressured except via pipe_stall_o; load/MDU wait on ready.
// Optional statistics counters are built when WB_ARB_STATS_EN is defined.
module wb_port_arbiter
    import cpu_consts::*;
#(
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT,
    parameter int XLEN         = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_wr_valid_i,
    input  logic [4:0]      pipe_wr_rd_i,
    input  logic [XLEN-1:0] pipe_wr_data_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [XLEN-1:0] ld_data_i,
    input  logic            mdu_valid_i,
    output logic            mdu_ready_o,
    input  logic [4:0]      mdu_rd_i,
    input  logic [XLEN-1:0] mdu_data_i,
    output logic            pipe_stall_o,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_wr_addr_o,
    output logic [XLEN-1:0] rf_wr_data_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]     stat_ld_conflict_o,
    output logic [31:0]     stat_mdu_conflict_o,
    output logic [31:0]     stat_bubble_o
`endif
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_BUBBLE = BUBBLE;

    localparam logic [4:0] LIMIT5 = 5'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

    logic            sec_any;
    logic            sec_blocked;
    logic [1:0]      sec_req;
    logic [1:0]      sec_gnt;
    logic            sec_granted;

    wb_src_e         src;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [4:0]      cnt_inc;
    logic            stall_d;

    assign sec_any     = ld_valid_i | mdu_valid_i;
    assign sec_blocked = pipe_wr_valid_i & sec_any;

    // The pipeline cannot be stalled in-cycle, so it masks both secondaries outright
    assign sec_req     = {mdu_valid_i, ld_valid_i} & {2{~pipe_wr_valid_i}};
    assign sec_granted = |sec_gnt;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (sec_req),
        .gnt     (sec_gnt),
        .advance (sec_granted)
    );

    // Readies must read low during reset even though the request path is combinational
    assign ld_ready_o  = sec_gnt[0] & ~reset;
    assign mdu_ready_o = sec_gnt[1] & ~reset;

    // Select the winning source and its write payload
    always_comb begin
        src      = WB_NONE;
        sel_rd   = 5'd0;
        sel_data = '0;
        if (pipe_wr_valid_i) begin
            src      = WB_PIPE;
            sel_rd   = pipe_wr_rd_i;
            sel_data = pipe_wr_data_i;
        end else if (sec_gnt[0]) begin
            src      = WB_LD;
            sel_rd   = ld_rd_i;
            sel_data = ld_data_i;
        end else if (sec_gnt[1]) begin
            src      = WB_MDU;
            sel_rd   = mdu_rd_i;
            sel_data = mdu_data_i;
        end
    end

    // Output stage: x0 writes still complete the handshake but never raise the enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_addr_o <= 5'd0;
            rf_wr_data_o <= '0;
        end else begin
            rf_wr_en_o <= (src != WB_NONE) && (sel_rd != 5'd0);
            if (src != WB_NONE) begin
                rf_wr_addr_o <= sel_rd;
                rf_wr_data_o <= sel_data;
            end
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    // Starvation watchdog: cnt_q counts blocked cycles already seen; the current
    // blocked cycle is cnt_q+1, so reaching the limit decides the bubble this cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sec_blocked) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd1;
                end
            end
            ST_WAIT: begin
                if (!sec_any || sec_granted) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_inc >= LIMIT5) begin
                    state_d = ST_BUBBLE;
                end else begin
                    cnt_d = cnt_inc[3:0];
                end
            end
            ST_BUBBLE: begin
                // Pipe ignored the stall: it still wins, and the bubble is re-requested
                if (sec_blocked) begin
                    state_d = ST_WAIT;
                    cnt_d   = LIMIT4;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Stall is raised one cycle ahead so the pipeline can drop valid in the bubble cycle
    assign stall_d = (state_d == ST_WAIT) && (({1'b0, cnt_d} + 5'd1) >= LIMIT5);

    // Watchdog state and registered stall pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pipe_stall_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pipe_stall_o <= stall_d;
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating event counters for conflict and bubble statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ld_conflict_o  <= 32'd0;
            stat_mdu_conflict_o <= 32'd0;
            stat_bubble_o       <= 32'd0;
        end else begin
            if (ld_valid_i && !ld_ready_o) begin
                stat_ld_conflict_o <= sat_inc32(stat_ld_conflict_o);
            end
            if (mdu_valid_i && !mdu_ready_o) begin
                stat_mdu_conflict_o <= sat_inc32(stat_mdu_conflict_o);
            end
            if (pipe_stall_o) begin
                stat_bubble_o <= sat_inc32(stat_bubble_o);
            end
        end
    end
`endif

endmodule
